// File: rtl/vending_if.sv
// Coin-acceptor / actuator bus for vending_ctrl.
// Optional audit counters exist only when VEND_AUDIT_EN is defined.
interface vending_if #(
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned STOCK_W  = 4
);
  logic [1:0]          coin;
  logic                cancel;
  logic                restock;
  logic                dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic                sold_out;
  logic [STOCK_W-1:0]  stock;
`ifdef VEND_AUDIT_EN
  logic [15:0]         sales_cnt;
  logic [23:0]         revenue;
`endif

  modport master (
    output coin, cancel, restock,
    input  dispense, change_valid, change, coin_rej, credit, sold_out, stock
`ifdef VEND_AUDIT_EN
    , input sales_cnt, revenue
`endif
  );

  modport slave (
    input  coin, cancel, restock,
    output dispense, change_valid, change, coin_rej, credit, sold_out, stock
`ifdef VEND_AUDIT_EN
    , output sales_cnt, revenue
`endif
  );
endinterface

// File: rtl/vending_ctrl.sv
// Parametrised three-coin vending controller with change, refund and stock tracking.
// Define VEND_AUDIT_EN to add saturating sales_cnt / revenue counters.
module vending_ctrl #(
  parameter int unsigned COIN1_VAL  = 5,
  parameter int unsigned COIN2_VAL  = 10,
  parameter int unsigned COIN3_VAL  = 20,
  parameter int unsigned PRICE      = 15,
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  vending_if.slave  bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]   C1_S    = SUM_W'(COIN1_VAL);
  localparam logic [SUM_W-1:0]   C2_S    = SUM_W'(COIN2_VAL);
  localparam logic [SUM_W-1:0]   C3_S    = SUM_W'(COIN3_VAL);
  localparam logic [SUM_W-1:0]   PRICE_S = SUM_W'(PRICE);
  localparam logic [STOCK_W-1:0] INIT_S  = STOCK_W'(STOCK_INIT);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, SOLDOUT} state_t;

  state_t              state_q, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic [STOCK_W-1:0]  stock_q, stock_nxt;
  logic [CREDIT_W-1:0] change_q, change_nxt;
  logic                dispense_q, dispense_nxt;
  logic                change_valid_q, change_valid_nxt;
  logic                coin_rej_q, coin_rej_nxt;
  logic                sold_out_q, sold_out_nxt;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;

  always_comb begin
    case (bus.coin)
      2'd1:    coin_val = C1_S;
      2'd2:    coin_val = C2_S;
      2'd3:    coin_val = C3_S;
      default: coin_val = '0;
    endcase
  end

  assign sum = {1'b0, credit_q} + coin_val;

  // Next-state and next-output decode; cancel is checked before vend.
  always_comb begin
    state_nxt        = state_q;
    credit_nxt       = credit_q;
    stock_nxt        = stock_q;
    change_nxt       = '0;
    dispense_nxt     = 1'b0;
    change_valid_nxt = 1'b0;
    coin_rej_nxt     = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (bus.cancel && (state_q == COLLECT || bus.coin != 2'd0)) begin
          change_valid_nxt = 1'b1;
          change_nxt       = CREDIT_W'(sum);
          credit_nxt       = '0;
          state_nxt        = IDLE;
        end else if (bus.coin != 2'd0) begin
          if (stock_q == '0) begin
            // Only reachable with STOCK_INIT==0: no item to vend, return the coin
            coin_rej_nxt = 1'b1;
            state_nxt    = SOLDOUT;
          end else if (sum < PRICE_S) begin
            credit_nxt = CREDIT_W'(sum);
            state_nxt  = COLLECT;
          end else begin
            dispense_nxt     = 1'b1;
            change_nxt       = CREDIT_W'(sum - PRICE_S);
            change_valid_nxt = (sum > PRICE_S);
            credit_nxt       = '0;
            stock_nxt        = stock_q - STOCK_W'(1);
            state_nxt        = VEND;
          end
        end
      end
      VEND: begin
        coin_rej_nxt = (bus.coin != 2'd0);
        state_nxt    = (stock_q == '0) ? SOLDOUT : IDLE;
      end
      SOLDOUT: begin
        coin_rej_nxt = (bus.coin != 2'd0);
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.restock) begin
      stock_nxt = INIT_S;
      if (state_nxt == SOLDOUT) state_nxt = IDLE;
    end

    sold_out_nxt = (stock_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      stock_q        <= INIT_S;
      change_q       <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_rej_q     <= 1'b0;
      sold_out_q     <= (INIT_S == '0);
    end else begin
      state_q        <= state_nxt;
      credit_q       <= credit_nxt;
      stock_q        <= stock_nxt;
      change_q       <= change_nxt;
      dispense_q     <= dispense_nxt;
      change_valid_q <= change_valid_nxt;
      coin_rej_q     <= coin_rej_nxt;
      sold_out_q     <= sold_out_nxt;
    end
  end

  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change       = change_q;
  assign bus.coin_rej     = coin_rej_q;
  assign bus.credit       = credit_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.stock        = stock_q;

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q;
  logic [23:0] revenue_q;
  logic [24:0] rev_sum;

  assign rev_sum = {1'b0, revenue_q} + 25'(PRICE);

  // Saturating audit counters; cleared by reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sales_q   <= '0;
      revenue_q <= '0;
    end else if (dispense_nxt) begin
      if (sales_q != '1) sales_q <= sales_q + 16'd1;
      revenue_q <= rev_sum[24] ? '1 : rev_sum[23:0];
    end
  end

  assign bus.sales_cnt = sales_q;
  assign bus.revenue   = revenue_q;
`endif

endmodule
